// File: rtl/uart_frame_codec_if.sv
// Byte-level handshake bundle between the framing codec, the UART transceiver
// and the TAP. The codec connects through the slave modport. The TAP/UART side,
// or a bench, connects through the master modport.
interface uart_frame_codec_if;
   // Receive side: UART receiver -> codec -> TAP
   logic [7:0] RX_DATA_I;
   logic       RX_VALID_I;
   logic       READ_I;
   logic [7:0] DATA_REC_O;
   logic       CMD_REC_O;
   logic       RX_EMPTY_O;
   logic       OVERFLOW_O;

   // Transmit side: TAP -> codec -> UART transmitter
   logic       TX_READY_O;
   logic       WRITE_I;
   logic [7:0] DATA_SEND_I;
   logic       SEND_COMMAND_I;
   logic [7:0] COMMAND_I;
   logic [7:0] TX_DATA_O;
   logic       TX_VALID_O;
   logic       TX_READY_I;

   modport master (
      output RX_DATA_I, RX_VALID_I, READ_I,
      output WRITE_I, DATA_SEND_I, SEND_COMMAND_I, COMMAND_I, TX_READY_I,
      input  DATA_REC_O, CMD_REC_O, RX_EMPTY_O, OVERFLOW_O,
      input  TX_READY_O, TX_DATA_O, TX_VALID_O
   );

   modport slave (
      input  RX_DATA_I, RX_VALID_I, READ_I,
      input  WRITE_I, DATA_SEND_I, SEND_COMMAND_I, COMMAND_I, TX_READY_I,
      output DATA_REC_O, CMD_REC_O, RX_EMPTY_O, OVERFLOW_O,
      output TX_READY_O, TX_DATA_O, TX_VALID_O
   );
endinterface

// File: rtl/uart_frame_codec.sv
// Escape-based byte framing between the UART transceiver and the DMI UART TAP.
// Receive path: the escape decoder feeds a first-word-fall-through FIFO of
// {cmd, byte} entries. Transmit path: single requests are expanded into one or
// two escaped UART bytes. The two paths share nothing but the clock and reset.
module uart_frame_codec #(
   parameter logic [7:0]  ESC   = 8'h1B,
   parameter int unsigned DEPTH = 8
) (
   input logic               CLK_I,
   input logic               RST_I,
   uart_frame_codec_if.slave codec_io
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

   // ---------------------------------------------------------------------------
   // Receive decoder
   // ---------------------------------------------------------------------------
   typedef enum logic {RxIdle, RxEsc} rx_state_e;

   rx_state_e  rx_state_q;
   logic       push;
   logic [8:0] push_entry;

   // Decide whether the incoming byte completes an entry, and what that entry is
   always_comb begin
      push       = 1'b0;
      push_entry = 9'h000;
      if (codec_io.RX_VALID_I) begin
         case (rx_state_q)
            RxIdle: begin
               if (codec_io.RX_DATA_I != ESC) begin
                  push       = 1'b1;
                  push_entry = {1'b0, codec_io.RX_DATA_I};
               end
            end
            RxEsc: begin
               push = 1'b1;
               // A doubled escape is a literal escape data byte
               if (codec_io.RX_DATA_I == ESC) begin
                  push_entry = {1'b0, ESC};
               end else begin
                  push_entry = {1'b1, codec_io.RX_DATA_I};
               end
            end
         endcase
      end
   end

   // Decoder state tracks whether the previous byte was an unpaired escape
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         rx_state_q <= RxIdle;
      end else if (codec_io.RX_VALID_I) begin
         case (rx_state_q)
            RxIdle: begin
               if (codec_io.RX_DATA_I == ESC) begin
                  rx_state_q <= RxEsc;
               end
            end
            RxEsc: rx_state_q <= RxIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Receive FIFO
   // ---------------------------------------------------------------------------
   logic [8:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [8:0]    last_q, last_d;
   logic          overflow_q, overflow_d;

   logic empty;
   logic full;
   logic pop;
   logic push_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == FullCnt);
   // A read on an empty FIFO is ignored, even if a push lands in the same cycle
   assign pop   = codec_io.READ_I && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign push_ok = push && (!full || pop);

   // Next-state for pointers, occupancy, last popped head and the sticky drop flag
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      last_d     = last_q;
      overflow_d = overflow_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         last_d   = mem_q[rd_ptr_q];
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (push && !push_ok) begin
         overflow_d = 1'b1;
      end
   end

   // FIFO control registers
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_q     <= 9'h000;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         last_q     <= last_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage; contents are only observable through valid pointers, so no reset
   always_ff @(posedge CLK_I) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   logic [8:0] head;

   // When empty the head keeps showing the most recently popped entry
   always_comb begin
      head = empty ? last_q : mem_q[rd_ptr_q];
   end

   assign codec_io.DATA_REC_O = head[7:0];
   assign codec_io.CMD_REC_O  = head[8];
   assign codec_io.RX_EMPTY_O = empty;
   assign codec_io.OVERFLOW_O = overflow_q;

   // ---------------------------------------------------------------------------
   // Transmit encoder
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {TxIdle, TxFirst, TxSecond} tx_state_e;

   tx_state_e  tx_state_q;
   logic [7:0] tx_data_q;
   logic       tx_valid_q;
   logic       tx_two_q;
   logic [7:0] tx_second_q;

   // Encoder FSM with registered byte/valid outputs; data only changes after a transfer
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         tx_state_q  <= TxIdle;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
         tx_two_q    <= 1'b0;
         tx_second_q <= 8'h00;
      end else begin
         unique case (tx_state_q)
            TxIdle: begin
               if (codec_io.WRITE_I) begin
                  tx_state_q <= TxFirst;
                  tx_valid_q <= 1'b1;
                  if (codec_io.SEND_COMMAND_I) begin
                     tx_data_q   <= ESC;
                     tx_second_q <= codec_io.COMMAND_I;
                     tx_two_q    <= 1'b1;
                  end else if (codec_io.DATA_SEND_I == ESC) begin
                     tx_data_q   <= ESC;
                     tx_second_q <= ESC;
                     tx_two_q    <= 1'b1;
                  end else begin
                     tx_data_q <= codec_io.DATA_SEND_I;
                     tx_two_q  <= 1'b0;
                  end
               end
            end
            TxFirst: begin
               if (codec_io.TX_READY_I) begin
                  if (tx_two_q) begin
                     tx_state_q <= TxSecond;
                     tx_data_q  <= tx_second_q;
                  end else begin
                     tx_state_q <= TxIdle;
                     tx_valid_q <= 1'b0;
                  end
               end
            end
            TxSecond: begin
               if (codec_io.TX_READY_I) begin
                  tx_state_q <= TxIdle;
                  tx_valid_q <= 1'b0;
               end
            end
            default: begin
               tx_state_q <= TxIdle;
               tx_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign codec_io.TX_READY_O = (tx_state_q == TxIdle);
   assign codec_io.TX_DATA_O  = tx_data_q;
   assign codec_io.TX_VALID_O = tx_valid_q;

endmodule

// File: tb/tb_uart_frame_codec.sv
// Self-checking bench for uart_frame_codec: directed and randomized receive and
// transmit traffic compared against a queue-based model of the framing rules.
module tb_uart_frame_codec;

   localparam logic [7:0]  ESC   = 8'h1B;
   localparam int unsigned DEPTH = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   uart_frame_codec_if bus ();

   uart_frame_codec #(
      .ESC   (ESC),
      .DEPTH (DEPTH)
   ) dut (
      .CLK_I    (clk),
      .RST_I    (rst),
      .codec_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of the receive side: decoded entries, pending escape,
   // sticky drop flag and the last entry the TAP popped.
   logic [8:0] mq [$];
   bit         m_esc;
   bit         m_ovf;
   logic [8:0] m_last;

   task automatic model_clear();
      mq.delete();
      m_esc  = 1'b0;
      m_ovf  = 1'b0;
      m_last = 9'h000;
   endtask

   // Drive one receive-side cycle from a negedge and advance the model
   task automatic rx_cycle(input bit v, input logic [7:0] b, input bit rd);
      bit         have;
      logic [8:0] e;
      logic [8:0] dummy;
      bus.RX_VALID_I = v;
      bus.RX_DATA_I  = b;
      bus.READ_I     = rd;
      have = 1'b0;
      e    = 9'h000;
      if (v) begin
         if (!m_esc) begin
            if (b == ESC) m_esc = 1'b1;
            else begin have = 1'b1; e = {1'b0, b}; end
         end else begin
            m_esc = 1'b0;
            have  = 1'b1;
            e     = (b == ESC) ? {1'b0, ESC} : {1'b1, b};
         end
      end
      if (rd && mq.size() > 0) begin
         dummy  = mq.pop_front();
         m_last = dummy;
      end
      if (have) begin
         if (mq.size() < DEPTH) mq.push_back(e);
         else m_ovf = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      bus.RX_VALID_I = 1'b0;
      bus.READ_I     = 1'b0;
   endtask

   task automatic do_reset();
      bus.RX_VALID_I     = 1'b0;
      bus.RX_DATA_I      = 8'h00;
      bus.READ_I         = 1'b0;
      bus.WRITE_I        = 1'b0;
      bus.DATA_SEND_I    = 8'h00;
      bus.SEND_COMMAND_I = 1'b0;
      bus.COMMAND_I      = 8'h00;
      bus.TX_READY_I     = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks += 7;
      if (bus.RX_EMPTY_O !== 1'b1) begin
         failures++; $display("FAIL reset_rx_empty got=%b want=1", bus.RX_EMPTY_O);
      end
      if (bus.TX_READY_O !== 1'b1) begin
         failures++; $display("FAIL reset_tx_ready got=%b want=1", bus.TX_READY_O);
      end
      if (bus.DATA_REC_O !== 8'h00) begin
         failures++; $display("FAIL reset_data_rec got=%h want=00", bus.DATA_REC_O);
      end
      if (bus.CMD_REC_O !== 1'b0) begin
         failures++; $display("FAIL reset_cmd_rec got=%b want=0", bus.CMD_REC_O);
      end
      if (bus.OVERFLOW_O !== 1'b0) begin
         failures++; $display("FAIL reset_overflow got=%b want=0", bus.OVERFLOW_O);
      end
      if (bus.TX_DATA_O !== 8'h00) begin
         failures++; $display("FAIL reset_tx_data got=%h want=00", bus.TX_DATA_O);
      end
      if (bus.TX_VALID_O !== 1'b0) begin
         failures++; $display("FAIL reset_tx_valid got=%b want=0", bus.TX_VALID_O);
      end
   endtask

   task automatic test_rx_decode();
      logic [7:0] stim [6];
      logic [8:0] want [4];
      stim = '{8'h42, 8'h1B, 8'h41, 8'h1B, 8'h1B, 8'h07};
      want = '{9'h042, 9'h141, 9'h01B, 9'h007};
      do_reset();
      rx_cycle(1'b1, stim[0], 1'b0);
      checks++;
      if (bus.RX_EMPTY_O !== 1'b0) begin
         failures++; $display("FAIL decode_empty_latency got=%b want=0", bus.RX_EMPTY_O);
      end
      for (int i = 1; i < 6; i++) rx_cycle(1'b1, stim[i], 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.CMD_REC_O, bus.DATA_REC_O} !== want[i] || want[i] !== mq[0]) begin
            failures++;
            $display("FAIL decode_pop%0d got=%h want=%h", i, {bus.CMD_REC_O, bus.DATA_REC_O},
                     want[i]);
         end
         rx_cycle(1'b0, 8'h00, 1'b1);
      end
      checks++;
      if (bus.RX_EMPTY_O !== 1'b1) begin
         failures++; $display("FAIL decode_final_empty got=%b want=1", bus.RX_EMPTY_O);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] want [8];
      want = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10};
      do_reset();
      for (int i = 1; i <= 8; i++) rx_cycle(1'b1, 8'(i), 1'b0);
      checks++;
      if (bus.OVERFLOW_O !== 1'b0) begin
         failures++; $display("FAIL ovf_before_full got=%b want=0", bus.OVERFLOW_O);
      end
      rx_cycle(1'b1, 8'd9, 1'b0);
      checks++;
      if (bus.OVERFLOW_O !== 1'b1) begin
         failures++; $display("FAIL ovf_set got=%b want=1", bus.OVERFLOW_O);
      end
      checks++;
      if ({bus.CMD_REC_O, bus.DATA_REC_O} !== 9'h001) begin
         failures++; $display("FAIL ovf_head got=%h want=001", {bus.CMD_REC_O, bus.DATA_REC_O});
      end
      // Push while full together with a pop must be accepted
      rx_cycle(1'b1, 8'd10, 1'b1);
      checks++;
      if (bus.OVERFLOW_O !== 1'b1) begin
         failures++; $display("FAIL full_push_pop_ovf got=%b want=1", bus.OVERFLOW_O);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.RX_EMPTY_O !== 1'b0 || {bus.CMD_REC_O, bus.DATA_REC_O} !== {1'b0, want[i]}) begin
            failures++;
            $display("FAIL full_pop%0d got=%h empty=%b want=%h", i,
                     {bus.CMD_REC_O, bus.DATA_REC_O}, bus.RX_EMPTY_O, {1'b0, want[i]});
         end
         rx_cycle(1'b0, 8'h00, 1'b1);
      end
      checks++;
      if (bus.RX_EMPTY_O !== 1'b1 || {bus.CMD_REC_O, bus.DATA_REC_O} !== 9'h00A) begin
         failures++;
         $display("FAIL full_drained got=%h empty=%b want=00a empty=1",
                  {bus.CMD_REC_O, bus.DATA_REC_O}, bus.RX_EMPTY_O);
      end
   endtask

   task automatic test_rx_random();
      bit         v;
      bit         rd;
      logic [7:0] b;
      logic [8:0] exp_head;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         v  = ($urandom % 4) != 0;
         b  = (($urandom % 4) == 0) ? ESC : 8'($urandom);
         rd = ($urandom % 3) == 0;
         rx_cycle(v, b, rd);
         exp_head = (mq.size() > 0) ? mq[0] : m_last;
         checks += 3;
         if (bus.RX_EMPTY_O !== (mq.size() == 0)) begin
            failures++;
            $display("FAIL rand_empty cycle=%0d got=%b want=%b", n, bus.RX_EMPTY_O, mq.size() == 0);
         end
         if ({bus.CMD_REC_O, bus.DATA_REC_O} !== exp_head) begin
            failures++;
            $display("FAIL rand_head cycle=%0d got=%h want=%h", n,
                     {bus.CMD_REC_O, bus.DATA_REC_O}, exp_head);
         end
         if (bus.OVERFLOW_O !== m_ovf) begin
            failures++;
            $display("FAIL rand_ovf cycle=%0d got=%b want=%b", n, bus.OVERFLOW_O, m_ovf);
         end
      end
   endtask

   task automatic test_tx_encode();
      logic [7:0] exp [$];
      logic [7:0] d;
      logic [7:0] c;
      logic [7:0] held;
      bit         is_cmd;
      bit         stalled;
      int         idx;
      int         guard;
      do_reset();
      for (int r = 0; r < 25; r++) begin
         if (r == 0) begin is_cmd = 1'b0; d = 8'h55; c = 8'h00; end
         else if (r == 1) begin is_cmd = 1'b0; d = 8'h1B; c = 8'h00; end
         else if (r == 2) begin is_cmd = 1'b1; d = 8'h00; c = 8'h03; end
         else begin
            is_cmd = ($urandom % 3) == 0;
            d      = (($urandom % 4) == 0) ? ESC : 8'($urandom);
            c      = 8'($urandom);
            if (c == ESC) c = c + 8'h01;
         end
         exp.delete();
         if (is_cmd) begin exp.push_back(ESC); exp.push_back(c); end
         else if (d == ESC) begin exp.push_back(ESC); exp.push_back(ESC); end
         else exp.push_back(d);

         checks++;
         if (bus.TX_READY_O !== 1'b1) begin
            failures++; $display("FAIL tx_idle_ready req=%0d got=%b want=1", r, bus.TX_READY_O);
         end
         bus.WRITE_I        = 1'b1;
         bus.SEND_COMMAND_I = is_cmd;
         bus.DATA_SEND_I    = d;
         bus.COMMAND_I      = c;
         bus.TX_READY_I     = 1'b0;
         @(posedge clk);
         @(negedge clk);
         idx     = 0;
         stalled = 1'b0;
         held    = 8'h00;
         guard   = 0;
         while (idx < exp.size() && guard < 100) begin
            guard++;
            checks += 2;
            if (bus.TX_VALID_O !== 1'b1) begin
               failures++; $display("FAIL tx_valid req=%0d got=%b want=1", r, bus.TX_VALID_O);
            end
            if (bus.TX_READY_O !== 1'b0) begin
               failures++; $display("FAIL tx_busy req=%0d got=%b want=0", r, bus.TX_READY_O);
            end
            if (stalled) begin
               checks++;
               if (bus.TX_DATA_O !== held) begin
                  failures++;
                  $display("FAIL tx_stable req=%0d got=%h want=%h", r, bus.TX_DATA_O, held);
               end
            end
            // Requests while busy must be ignored
            bus.WRITE_I        = 1'($urandom);
            bus.SEND_COMMAND_I = 1'($urandom);
            bus.DATA_SEND_I    = 8'($urandom);
            bus.COMMAND_I      = 8'($urandom);
            bus.TX_READY_I     = ($urandom % 3) != 0;
            if (bus.TX_READY_I) begin
               checks++;
               if (bus.TX_DATA_O !== exp[idx]) begin
                  failures++;
                  $display("FAIL tx_byte req=%0d idx=%0d got=%h want=%h", r, idx, bus.TX_DATA_O,
                           exp[idx]);
               end
               idx++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = bus.TX_DATA_O;
            end
            @(posedge clk);
            @(negedge clk);
         end
         bus.WRITE_I    = 1'b0;
         bus.TX_READY_I = 1'b0;
         checks += 2;
         if (idx < exp.size()) begin
            failures++; $display("FAIL tx_timeout req=%0d got=%0d want=%0d", r, idx, exp.size());
         end
         if (bus.TX_READY_O !== 1'b1 || bus.TX_VALID_O !== 1'b0) begin
            failures++;
            $display("FAIL tx_done req=%0d got ready=%b valid=%b want ready=1 valid=0", r,
                     bus.TX_READY_O, bus.TX_VALID_O);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      // Leave an escape pending on receive
      rx_cycle(1'b1, ESC, 1'b0);
      // Start a command send and let its escape byte go out
      bus.WRITE_I        = 1'b1;
      bus.SEND_COMMAND_I = 1'b1;
      bus.COMMAND_I      = 8'h05;
      @(posedge clk);
      @(negedge clk);
      bus.WRITE_I    = 1'b0;
      bus.TX_READY_I = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.TX_VALID_O !== 1'b1 || bus.TX_DATA_O !== 8'h05) begin
         failures++;
         $display("FAIL mid_second_pending got valid=%b data=%h want valid=1 data=05",
                  bus.TX_VALID_O, bus.TX_DATA_O);
      end
      bus.TX_READY_I = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.TX_VALID_O !== 1'b0 || bus.TX_READY_O !== 1'b1 || bus.RX_EMPTY_O !== 1'b1) begin
         failures++;
         $display("FAIL mid_async_clear got valid=%b ready=%b empty=%b want 0 1 1",
                  bus.TX_VALID_O, bus.TX_READY_O, bus.RX_EMPTY_O);
      end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      bus.TX_READY_I = 1'b1;
      rx_cycle(1'b1, 8'h41, 1'b0);
      checks++;
      if (bus.RX_EMPTY_O !== 1'b0 || {bus.CMD_REC_O, bus.DATA_REC_O} !== 9'h041) begin
         failures++;
         $display("FAIL mid_rx_after got=%h empty=%b want=041 empty=0",
                  {bus.CMD_REC_O, bus.DATA_REC_O}, bus.RX_EMPTY_O);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.TX_VALID_O !== 1'b0) begin
            failures++; $display("FAIL mid_no_second got=%b want=0", bus.TX_VALID_O);
         end
         @(posedge clk);
         @(negedge clk);
      end
      bus.TX_READY_I = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      model_clear();
      @(negedge clk);
      test_reset();
      test_rx_decode();
      test_overflow();
      test_rx_random();
      test_tx_encode();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
